conv_frame_encoder: RTL

Hardware K=3, rate-1/2 convolutional encoder (generators 7 and 5, octal) that turns one `DATA_W`-bit raw word into a `2*DATA_W`-bit encoded frame. Its frame format is exactly what the Viterbi decoder path (`system_top`) accepts on `data_i`/`dvalid_i`. It sits on the transmit side ahead of the channel/decoder:
- Processes one bit per clock.
- Holds each finished frame until the downstream consumer accepts it.

---
 rtl/conv_enc_pkg.sv | 25 ++
 rtl/conv_enc_step.sv | 15 +
 rtl/conv_frame_encoder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/conv_enc_pkg.sv
// Shared types and code constants for the K=3, rate-1/2 convolutional encoder.
// Generators are 7/5 octal; used by both the RTL and the bench reference model.
package conv_enc_pkg;

  localparam int K = 3;
  localparam logic [K-1:0] G1 = 3'b111;
  localparam logic [K-1:0] G0 = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  // Register image is {b, s[1], s[0]}; each output bit is the parity of its taps.
  function automatic logic [1:0] conv_bits(
    input logic       b,
    input logic [1:0] s
  );
    logic [K-1:0] r;
    r = {b, s};
    return {^(r & G1), ^(r & G0)};
  endfunction

endpackage

// File: rtl/conv_enc_step.sv
// Combinational single-bit step of the 7/5 convolutional code.
// Produces {c1,c0} for input bit b and the next shift state.
module conv_enc_step
  import conv_enc_pkg::*;
(
  input  logic       b_i,
  input  logic [1:0] s_i,
  output logic [1:0] code_o,
  output logic [1:0] s_next_o
);

  assign code_o   = conv_bits(b_i, s_i);
  assign s_next_o = {b_i, s_i[1]};

endmodule

// File: rtl/conv_frame_encoder.sv
// Word-to-frame convolutional encoder, one bit per clock, frame held until taken.
// Define CONV_ENC_STREAM_EN to carry the trellis state across frames.
module conv_frame_encoder
  import conv_enc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dvalid_i,
  input  logic [DATA_W-1:0]     data_i,
  output logic                  ready_o,
  output logic [2*DATA_W-1:0]   data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  overrun_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int FW    = 2 * DATA_W;

`ifdef CONV_ENC_STREAM_EN
  localparam bit CLR_S = 1'b0;
`else
  localparam bit CLR_S = 1'b1;
`endif

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          s_q, s_d;
  logic [FW-1:0]       acc_q, acc_d;
  logic [FW-1:0]       frame_q, frame_d;
  logic                ovr_q, ovr_d;
  logic                dv_q;

  logic [1:0]          code;
  logic [1:0]          s_nxt;
  logic                accept;

  conv_enc_step u_step (
    .b_i      (word_q[DATA_W-1]),
    .s_i      (s_q),
    .code_o   (code),
    .s_next_o (s_nxt)
  );

  assign valid_o   = (state_q == HOLD);
  assign busy_o    = (state_q != IDLE);
  assign ready_o   = (state_q == IDLE) | (valid_o & ready_i);
  assign accept    = dvalid_i & ready_o;
  assign data_o    = frame_q;
  assign overrun_o = ovr_q;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    acc_d   = acc_q;
    frame_d = frame_q;
    // A held dvalid_i is one pending request; only a fresh one while blocked is lost.
    ovr_d   = ovr_q | (dvalid_i & ~ready_o & ~dv_q);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ENCODE;
          word_d  = data_i;
          cnt_d   = CNT_W'(DATA_W - 1);
          s_d     = CLR_S ? 2'b00 : s_q;
        end
      end
      ENCODE: begin
        word_d = word_q << 1;
        acc_d  = {acc_q[FW-3:0], code};
        s_d    = s_nxt;
        if (cnt_q == '0) begin
          state_d = HOLD;
          frame_d = {acc_q[FW-3:0], code};
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (accept) begin
          state_d = ENCODE;
          word_d  = data_i;
          cnt_d   = CNT_W'(DATA_W - 1);
          s_d     = CLR_S ? 2'b00 : s_q;
        end else if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      s_q     <= 2'b00;
      acc_q   <= '0;
      frame_q <= '0;
      ovr_q   <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      acc_q   <= acc_d;
      frame_q <= frame_d;
      ovr_q   <= ovr_d;
      dv_q    <= dvalid_i;
    end
  end

endmodule
